// File: rtl/sram_bist_pkg.sv
// Shared definitions for the SRAM BIST master: FSM state encoding,
// pattern-select encoding, LFSR polynomial, checkerboard words and
// small helpers for the LFSR.
package sram_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    PAT_INDEX     = 2'd0,
    PAT_INV_INDEX = 2'd1,
    PAT_CHECKER   = 2'd2,
    PAT_LFSR      = 2'd3
  } pattern_t;

  // Galois mask for x^32 + x^22 + x^2 + x + 1, right-shifting form.
  localparam logic [31:0] LFSR_POLY    = 32'h8020_0003;
  localparam logic [31:0] CHECKER_EVEN = 32'hAAAA_AAAA;
  localparam logic [31:0] CHECKER_ODD  = 32'h5555_5555;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0);
  endfunction

  // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
  function automatic logic [31:0] fix_seed(input logic [31:0] s);
    return (s == 32'h0) ? 32'h1 : s;
  endfunction

endpackage

// File: rtl/sram_bist_master_if.sv
// Avalon-MM bus between the BIST master and the SRAM slave.
// Handshake: a command (avm_write or avm_read) together with its address
// and data is accepted on a rising clk edge where avm_waitrequest=0; while
// avm_waitrequest=1 the master holds command, address and data stable.
// Read data returns a fixed number of cycles after acceptance.
interface sram_bist_master_if #(
  parameter int ADDR_W = 10
);
  logic [ADDR_W+1:0] avm_address;
  logic [3:0]        avm_byteenable;
  logic              avm_write;
  logic              avm_read;
  logic [31:0]       avm_writedata;
  logic              avm_waitrequest;
  logic [31:0]       avm_readdata;

  modport master (
    output avm_address, avm_byteenable, avm_write, avm_read, avm_writedata,
    input  avm_waitrequest, avm_readdata
  );

  modport slave (
    input  avm_address, avm_byteenable, avm_write, avm_read, avm_writedata,
    output avm_waitrequest, avm_readdata
  );
endinterface

// File: rtl/sram_bist_patgen.sv
// Pattern generator: maps (pattern, index, LFSR state) to a 32-bit word.
// Ports: clk, reset_n; pattern select; index (word index); step advances
// the LFSR once; reload loads reload_value (has priority over step);
// word is the pattern word for the current index / LFSR state.
module sram_bist_patgen
  import sram_bist_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  pattern_t          pattern,
  input  logic [ADDR_W-1:0] index,
  input  logic              step,
  input  logic              reload,
  input  logic [31:0]       reload_value,
  output logic [31:0]       word
);

  logic [31:0] lfsr;
  logic [31:0] index_ext;

  assign index_ext = {{(32-ADDR_W){1'b0}}, index};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr <= 32'h0;
    end else if (reload) begin
      lfsr <= reload_value;
    end else if (step) begin
      lfsr <= lfsr_next(lfsr);
    end
  end

  // The word of an access is the LFSR state before that access steps it.
  always_comb begin
    word = index_ext;
    case (pattern)
      PAT_INDEX:     word = index_ext;
      PAT_INV_INDEX: word = ~index_ext;
      PAT_CHECKER:   word = index[0] ? CHECKER_ODD : CHECKER_EVEN;
      PAT_LFSR:      word = lfsr;
      default:       word = index_ext;
    endcase
  end

endmodule

// File: rtl/sram_bist_master.sv
// SRAM BIST master: writes DEPTH words of a selected pattern over
// Avalon-MM, reads them back and counts mismatches.
// Ports: clk, reset_n (async, active low); start (pulse), abort (level),
// pattern, seed; avm (Avalon-MM master bus); busy/done/pass status;
// err_count (saturating), first_err_addr (word index); fsm_state (debug).
module sram_bist_master
  import sram_bist_pkg::*;
#(
  parameter int DEPTH        = 1024,
  parameter int ADDR_W       = 10,
  parameter int READ_LATENCY = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic [1:0]                pattern,
  input  logic [31:0]               seed,
  sram_bist_master_if.master        avm,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [15:0]               err_count,
  output logic [ADDR_W-1:0]         first_err_addr,
  output state_t                    fsm_state
);

  localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(DEPTH - 1);
  localparam logic [1:0]        DRAIN_LAST = 2'(READ_LATENCY - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] index;
  pattern_t          pat_q;
  logic [31:0]       seed_q;
  logic [1:0]        drain_cnt;
  logic [31:0]       word;

  logic start_ok, abort_act, wr_acc, rd_acc, last_idx, mismatch;

  logic [READ_LATENCY-1:0] vld_pipe;
  logic [31:0]             exp_pipe [READ_LATENCY];
  logic [ADDR_W-1:0]       idx_pipe [READ_LATENCY];

  assign start_ok  = start && !abort && (state == ST_IDLE || state == ST_DONE);
  assign abort_act = abort && (state != ST_IDLE);
  assign wr_acc    = (state == ST_WRITE) && !abort && !avm.avm_waitrequest;
  assign rd_acc    = (state == ST_READ)  && !abort && !avm.avm_waitrequest;
  assign last_idx  = (index == LAST_IDX);
  // Read data is compared a fixed latency after acceptance; abort discards it.
  assign mismatch  = vld_pipe[READ_LATENCY-1] && !abort &&
                     (avm.avm_readdata != exp_pipe[READ_LATENCY-1]);
  assign fsm_state = state;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (abort_act) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: if (start_ok)            state_nxt = ST_WRITE;
        ST_WRITE:         if (wr_acc && last_idx)  state_nxt = ST_READ;
        ST_READ:          if (rd_acc && last_idx)  state_nxt = ST_DRAIN;
        ST_DRAIN:         if (drain_cnt == DRAIN_LAST) state_nxt = ST_DONE;
        default:          state_nxt = ST_IDLE;
      endcase
    end
  end

  // Outputs; abort drops the bus command combinationally.
  always_comb begin
    busy               = (state == ST_WRITE) || (state == ST_READ) || (state == ST_DRAIN);
    done               = (state == ST_DONE);
    pass               = done && (err_count == 16'h0);
    avm.avm_write      = (state == ST_WRITE) && !abort;
    avm.avm_read       = (state == ST_READ) && !abort;
    avm.avm_byteenable = 4'hF;
    avm.avm_address    = (avm.avm_write || avm.avm_read) ? {index, 2'b00} : '0;
    avm.avm_writedata  = avm.avm_write ? word : 32'h0;
  end

  // The LFSR is reloaded at start and again on entry to READ so that the
  // read phase regenerates the exact write sequence.
  sram_bist_patgen #(.ADDR_W(ADDR_W)) u_patgen (
    .clk          (clk),
    .reset_n      (reset_n),
    .pattern      (pat_q),
    .index        (index),
    .step         (wr_acc || rd_acc),
    .reload       (start_ok || (wr_acc && last_idx)),
    .reload_value (start_ok ? fix_seed(seed) : seed_q),
    .word         (word)
  );

  // Index, latched configuration, drain counter and error bookkeeping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      index          <= '0;
      pat_q          <= PAT_INDEX;
      seed_q         <= 32'h0;
      drain_cnt      <= 2'd0;
      err_count      <= 16'h0;
      first_err_addr <= '0;
    end else begin
      drain_cnt <= (state == ST_DRAIN && !abort) ? drain_cnt + 2'd1 : 2'd0;
      if (start_ok) begin
        pat_q          <= pattern_t'(pattern);
        seed_q         <= fix_seed(seed);
        err_count      <= 16'h0;
        first_err_addr <= '0;
        index          <= '0;
      end else begin
        if (wr_acc || rd_acc) index <= last_idx ? '0 : index + 1'b1;
        if (mismatch) begin
          if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
          if (err_count == 16'h0)    first_err_addr <= idx_pipe[READ_LATENCY-1];
        end
      end
    end
  end

  // Expected-word pipeline, one stage per cycle of read latency
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe <= '0;
      for (int k = 0; k < READ_LATENCY; k++) begin
        exp_pipe[k] <= 32'h0;
        idx_pipe[k] <= '0;
      end
    end else if (abort_act) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= rd_acc;
      exp_pipe[0] <= word;
      idx_pipe[0] <= index;
      for (int k = 1; k < READ_LATENCY; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        exp_pipe[k] <= exp_pipe[k-1];
        idx_pipe[k] <= idx_pipe[k-1];
      end
    end
  end

endmodule
